// File: rtl/dilated_tap_buffer.sv
// Circular store of packed activation vectors feeding a dilated conv1d stage.
// Presents the newest vector and the ones DILATION, 2*DILATION and 3*DILATION writes older.
module dilated_tap_buffer #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 4   // legal range 1..64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_v,
  input  logic [D*W-1:0]   inp,
  output logic [D*W-1:0]   out_l0,
  output logic [D*W-1:0]   out_l1,
  output logic [D*W-1:0]   out_l2,
  output logic [D*W-1:0]   out_l3,
  output logic             out_v,
  output logic             primed
);

  localparam int DEPTH = 3 * DILATION + 1;
  localparam int VW    = D * W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [VW-1:0] entry_reg [DEPTH];
  logic [PW-1:0] wp_reg;
  logic [PW-1:0] wp_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          out_v_reg;
  logic          primed_reg;
  logic          clear;

  assign clear = rst | flush;

  always_comb begin
    wp_next  = (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
    cnt_next = (cnt_reg == FULL) ? FULL : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wp_reg     <= '0;
      cnt_reg    <= '0;
      out_v_reg  <= 1'b0;
      primed_reg <= 1'b0;
    end else begin
      out_v_reg <= in_v;
      if (in_v) begin
        wp_reg     <= wp_next;
        cnt_reg    <= cnt_next;
        primed_reg <= (cnt_next == FULL);
      end
    end
  end

  // Storage is cleared on rst/flush so unwritten history reads as zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (in_v) begin
      entry_reg[wp_reg] <= inp;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      logic [VW-1:0] src;
      logic [VW-1:0] tap_reg;

      if (gi == 0) begin : g_bypass
        assign src = inp;
      end else begin : g_read
        // Pre-increment wp points at the slot being overwritten, so wp-1 is the previous write.
        localparam logic [PW-1:0] OFS  = PW'(gi * DILATION);
        localparam logic [PW-1:0] WRAP = PW'(DEPTH - gi * DILATION);
        logic [PW-1:0] idx;
        assign idx = (wp_reg >= OFS) ? (wp_reg - OFS) : (wp_reg + WRAP);
        assign src = entry_reg[idx];
      end

      always_ff @(posedge clk) begin
        if (clear) begin
          tap_reg <= '0;
        end else if (in_v) begin
          tap_reg <= src;
        end
      end
    end
  endgenerate

  assign out_l0 = g_tap[0].tap_reg;
  assign out_l1 = g_tap[1].tap_reg;
  assign out_l2 = g_tap[2].tap_reg;
  assign out_l3 = g_tap[3].tap_reg;
  assign out_v  = out_v_reg;
  assign primed = primed_reg;

endmodule

// File: tb/tb_dilated_tap_buffer.sv
// Scoreboard bench for dilated_tap_buffer: a history-list model predicts each tap set,
// a negedge monitor checks every out_v pulse against the queued expectation.
module tb_dilated_tap_buffer;

  localparam int W     = 16;
  localparam int D     = 8;
  localparam int DIL   = 4;
  localparam int DEPTH = 3 * DIL + 1;
  localparam int VW    = D * W;

  typedef struct packed {
    logic [3:0][VW-1:0] tap;
    logic               pr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_v = 1'b0;
  logic [VW-1:0] inp = '0;
  logic [VW-1:0] out_l0, out_l1, out_l2, out_l3;
  logic          out_v, primed;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] hist[$];
  exp_t          exp_q[$];

  dilated_tap_buffer #(.W(W), .D(D), .DILATION(DIL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_v(in_v), .inp(inp),
    .out_l0(out_l0), .out_l1(out_l1), .out_l2(out_l2), .out_l3(out_l3),
    .out_v(out_v), .primed(primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input int n);
    logic [VW-1:0] v;
    logic [W-1:0]  e;
    e = W'(n);
    for (int i = 0; i < D; i++) v[i*W +: W] = e;
    return v;
  endfunction

  // Model: tap k is the vector written k*DIL writes before the newest, zero if none.
  function automatic exp_t model_now();
    exp_t e;
    int   idx;
    for (int k = 0; k < 4; k++) begin
      idx = hist.size() - 1 - k * DIL;
      e.tap[k] = (idx >= 0) ? hist[idx] : '0;
    end
    e.pr = (hist.size() >= DEPTH);
    return e;
  endfunction

  // One clock cycle of stimulus; returns 1 ns after the sampling edge.
  task automatic drive(input logic iv, input logic [VW-1:0] v, input logic fl, input logic rs);
    in_v  = iv;
    inp   = v;
    flush = fl;
    rst   = rs;
    if (rs || fl) begin
      hist.delete();
    end else if (iv) begin
      hist.push_back(v);
      exp_q.push_back(model_now());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string name, input logic exp_v);
    exp_t e;
    e = model_now();
    chk({name, "_l0"}, out_l0, e.tap[0]);
    chk({name, "_l1"}, out_l1, e.tap[1]);
    chk({name, "_l2"}, out_l2, e.tap[2]);
    chk({name, "_l3"}, out_l3, e.tap[3]);
    chk({name, "_primed"}, VW'(primed), VW'(e.pr));
    chk({name, "_out_v"}, VW'(out_v), VW'(exp_v));
  endtask

  // Monitor: every out_v pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_v === 1'b1) begin
      chk("unexpected_out_v", VW'(exp_q.size() > 0), VW'(1));
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_l0", out_l0, e.tap[0]);
        chk("sb_l1", out_l1, e.tap[1]);
        chk("sb_l2", out_l2, e.tap[2]);
        chk("sb_l3", out_l3, e.tap[3]);
        chk("sb_primed", VW'(primed), VW'(e.pr));
      end
    end
  end

  initial begin
    logic [VW-1:0] mixed;
    logic [VW-1:0] rv;
    logic [W-1:0]  mel [D];
    int            r;

    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, vec(99), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk_state("reset", 1'b0);
    chk("reset_l0_zero", out_l0, '0);

    // Fill ramp: one write every 3 cycles.
    for (int n = 1; n <= DEPTH; n++) begin
      drive(1'b1, vec(n), 1'b0, 1'b0);
      if (n == 5) chk("ramp5_l1", out_l1, vec(1));
      if (n == 9) chk("ramp9_l2", out_l2, vec(1));
      if (n == 12) chk("ramp12_primed", VW'(primed), VW'(0));
      if (n == 13) begin
        chk("ramp13_l3", out_l3, vec(1));
        chk("ramp13_primed", VW'(primed), VW'(1));
      end
      idle(2);
    end

    // Wrap-around at full rate.
    for (int n = DEPTH + 1; n <= 30; n++) begin
      drive(1'b1, vec(n), 1'b0, 1'b0);
      chk("burst_out_v", VW'(out_v), VW'(1));
      chk("burst_l3", out_l3, vec(n - 12));
    end

    // Hold.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      chk_state("hold", 1'b0);
    end
    chk("hold_l1_26", out_l1, vec(26));

    // Flush together with a write discards the write.
    drive(1'b1, vec(31), 1'b1, 1'b0);
    chk_state("flush", 1'b0);
    chk("flush_l0_zero", out_l0, '0);
    drive(1'b1, vec(7), 1'b0, 1'b0);
    chk("after_flush_l0", out_l0, vec(7));
    chk("after_flush_l1", out_l1, '0);
    idle(2);

    // Reset, then a signed mixed vector passed bit-exact.
    drive(1'b0, '0, 1'b0, 1'b1);
    chk_state("rst2", 1'b0);
    mel = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 16'h1234, 16'hABCD};
    for (int i = 0; i < D; i++) mixed[i*W +: W] = mel[i];
    drive(1'b1, mixed, 1'b0, 1'b0);
    chk("mixed_l0", out_l0, mixed);
    idle(1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    drive(1'b1, vec(5), 1'b0, 1'b1);
    chk_state("rst_burst", 1'b0);

    // Randomized traffic with occasional flush/reset.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      rv = {$urandom, $urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 1)), rv, r < 2, r == 2);
      if (r <= 2) chk_state("rand_clear", 1'b0);
    end
    idle(3);
    chk_state("final", 1'b0);
    chk("pending_expectations", VW'(exp_q.size()), VW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
